// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serialises note events, scans the voice bank one
// voice per cycle, then commits the note to a retriggered, free or stolen voice.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ev_valid,
    output logic                       ev_ready,
    input  logic [1:0]                 ev_type,
    input  logic [6:0]                 ev_note,
    input  logic [1:0]                 ev_wave,
    output logic [20*NUM_VOICES-1:0]   voice_freq,
    output logic [2*NUM_VOICES-1:0]    voice_ctrl,
    output logic [NUM_VOICES-1:0]      voice_gate,
    output logic [NUM_VOICES-1:0]      voice_rst,
    output logic                       steal
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ev_ready_q, ev_ready_d;
    logic [1:0]         type_q, type_d;
    logic [6:0]         note_q, note_d;
    logic [1:0]         wave_q, wave_d;

    logic               match_hit_q, match_hit_d;
    logic [IDX_W-1:0]   match_idx_q, match_idx_d;
    logic               free_hit_q, free_hit_d;
    logic [IDX_W-1:0]   free_idx_q, free_idx_d;
    logic               old_hit_q, old_hit_d;
    logic [IDX_W-1:0]   old_idx_q, old_idx_d;
    logic [AGE_W-1:0]   old_age_q, old_age_d;

    logic [19:0]        freq_q  [NUM_VOICES];
    logic [19:0]        freq_d  [NUM_VOICES];
    logic [1:0]         ctrl_q  [NUM_VOICES];
    logic [1:0]         ctrl_d  [NUM_VOICES];
    logic [6:0]         vnote_q [NUM_VOICES];
    logic [6:0]         vnote_d [NUM_VOICES];
    logic [AGE_W-1:0]   age_q   [NUM_VOICES];
    logic [AGE_W-1:0]   age_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] vrst_q, vrst_d;
    logic               steal_q, steal_d;

    logic [IDX_W-1:0]   tgt_s;
    logic               is_steal_s;

    // Octave-10 table, shifted down by (10 - octave); note 127 sits in octave 10.
    function automatic logic [19:0] freq_lookup(input logic [6:0] n);
        logic [19:0] base;
        logic [3:0]  oct;
        oct = 4'(n / 7'd12);
        case (4'(n % 7'd12))
            4'd0:    base = 20'd267905;
            4'd1:    base = 20'd283835;
            4'd2:    base = 20'd300713;
            4'd3:    base = 20'd318594;
            4'd4:    base = 20'd337539;
            4'd5:    base = 20'd357610;
            4'd6:    base = 20'd378874;
            4'd7:    base = 20'd401403;
            4'd8:    base = 20'd425272;
            4'd9:    base = 20'd450560;
            4'd10:   base = 20'd477352;
            4'd11:   base = 20'd505737;
            default: base = 20'd0;
        endcase
        return base >> (4'd10 - oct);
    endfunction

    // Next-state, scan bookkeeping and commit of voice state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        type_d      = type_q;
        note_d      = note_q;
        wave_d      = wave_q;
        match_hit_d = match_hit_q;
        match_idx_d = match_idx_q;
        free_hit_d  = free_hit_q;
        free_idx_d  = free_idx_q;
        old_hit_d   = old_hit_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        freq_d      = freq_q;
        ctrl_d      = ctrl_q;
        vnote_d     = vnote_q;
        age_d       = age_q;
        gate_d      = gate_q;
        vrst_d      = {NUM_VOICES{1'b0}};
        steal_d     = 1'b0;
        tgt_s       = {IDX_W{1'b0}};
        is_steal_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ev_valid && ev_ready_q) begin
                    type_d      = ev_type;
                    note_d      = ev_note;
                    wave_d      = ev_wave;
                    match_hit_d = 1'b0;
                    match_idx_d = {IDX_W{1'b0}};
                    free_hit_d  = 1'b0;
                    free_idx_d  = {IDX_W{1'b0}};
                    old_hit_d   = 1'b0;
                    old_idx_d   = {IDX_W{1'b0}};
                    old_age_d   = {AGE_W{1'b0}};
                    idx_d       = {IDX_W{1'b0}};
                    state_d     = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (gate_q[idx_q]) begin
                    if (!match_hit_q && (vnote_q[idx_q] == note_q)) begin
                        match_hit_d = 1'b1;
                        match_idx_d = idx_q;
                    end else begin
                        match_hit_d = match_hit_q;
                    end
                    // Strict compare keeps the lowest index on an age tie.
                    if (!old_hit_q || (age_q[idx_q] > old_age_q)) begin
                        old_hit_d = 1'b1;
                        old_idx_d = idx_q;
                        old_age_d = age_q[idx_q];
                    end else begin
                        old_hit_d = old_hit_q;
                    end
                end else begin
                    if (!free_hit_q) begin
                        free_hit_d = 1'b1;
                        free_idx_d = idx_q;
                    end else begin
                        free_hit_d = free_hit_q;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                case (type_q)
                    2'b01: begin
                        if (match_hit_q) begin
                            tgt_s = match_idx_q;
                        end else if (free_hit_q) begin
                            tgt_s = free_idx_q;
                        end else begin
                            tgt_s      = old_idx_q;
                            is_steal_s = 1'b1;
                        end
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (gate_q[v] && (IDX_W'(v) != tgt_s) && (age_q[v] != AGE_MAX)) begin
                                age_d[v] = age_q[v] + AGE_W'(1);
                            end else begin
                                age_d[v] = age_q[v];
                            end
                        end
                        freq_d[tgt_s]  = freq_lookup(note_q);
                        ctrl_d[tgt_s]  = wave_q;
                        vnote_d[tgt_s] = note_q;
                        age_d[tgt_s]   = {AGE_W{1'b0}};
                        gate_d[tgt_s]  = 1'b1;
                        vrst_d[tgt_s]  = 1'b1;
                        steal_d        = is_steal_s;
                    end
                    2'b00: begin
                        if (match_hit_q) begin
                            gate_d[match_idx_q] = 1'b0;
                        end else begin
                            gate_d = gate_q;
                        end
                    end
                    2'b10: begin
                        gate_d = {NUM_VOICES{1'b0}};
                    end
                    default: begin
                        gate_d = gate_q;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ev_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset abandons any in-flight event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            ev_ready_q  <= 1'b1;
            type_q      <= 2'b00;
            note_q      <= 7'd0;
            wave_q      <= 2'b00;
            match_hit_q <= 1'b0;
            match_idx_q <= {IDX_W{1'b0}};
            free_hit_q  <= 1'b0;
            free_idx_q  <= {IDX_W{1'b0}};
            old_hit_q   <= 1'b0;
            old_idx_q   <= {IDX_W{1'b0}};
            old_age_q   <= {AGE_W{1'b0}};
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_q[v]  <= 20'd0;
                ctrl_q[v]  <= 2'b00;
                vnote_q[v] <= 7'd0;
                age_q[v]   <= {AGE_W{1'b0}};
            end
            gate_q      <= {NUM_VOICES{1'b0}};
            vrst_q      <= {NUM_VOICES{1'b0}};
            steal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ev_ready_q  <= ev_ready_d;
            type_q      <= type_d;
            note_q      <= note_d;
            wave_q      <= wave_d;
            match_hit_q <= match_hit_d;
            match_idx_q <= match_idx_d;
            free_hit_q  <= free_hit_d;
            free_idx_q  <= free_idx_d;
            old_hit_q   <= old_hit_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            freq_q      <= freq_d;
            ctrl_q      <= ctrl_d;
            vnote_q     <= vnote_d;
            age_q       <= age_d;
            gate_q      <= gate_d;
            vrst_q      <= vrst_d;
            steal_q     <= steal_d;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
        assign voice_freq[20*g +: 20] = freq_q[g];
        assign voice_ctrl[2*g +: 2]   = ctrl_q[g];
    end

    assign voice_gate = gate_q;
    assign voice_rst  = vrst_q;
    assign steal      = steal_q;
    assign ev_ready   = ev_ready_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed test-plan steps followed by
// randomized events, all checked against a rule-level voice model.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int AW = 8;
    localparam int AGE_MAX = (1 << AW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              ev_valid;
    logic              ev_ready;
    logic [1:0]        ev_type;
    logic [6:0]        ev_note;
    logic [1:0]        ev_wave;
    logic [20*NV-1:0]  voice_freq;
    logic [2*NV-1:0]   voice_ctrl;
    logic [NV-1:0]     voice_gate;
    logic [NV-1:0]     voice_rst;
    logic              steal;

    int n_pass   = 0;
    int n_checks = 0;

    int m_gate [NV];
    int m_note [NV];
    int m_freq [NV];
    int m_ctrl [NV];
    int m_age  [NV];

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_type    (ev_type),
        .ev_note    (ev_note),
        .ev_wave    (ev_wave),
        .voice_freq (voice_freq),
        .voice_ctrl (voice_ctrl),
        .voice_gate (voice_gate),
        .voice_rst  (voice_rst),
        .steal      (steal)
    );

    always #5 clk = ~clk;

    function automatic int ref_freq(int n);
        real base;
        int  t;
        base = 450560.0 * (2.0 ** (real'((n % 12) - 9) / 12.0));
        t = $rtoi(base + 0.5);
        return t >> (10 - n / 12);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 0; m_note[v] = 0; m_freq[v] = 0; m_ctrl[v] = 0; m_age[v] = 0;
        end
    endtask

    task automatic model_event(input int typ, input int note, input int wave,
                               output int exp_rst, output int exp_steal);
        int tgt;
        exp_rst = 0;
        exp_steal = 0;
        if (typ == 1) begin
            tgt = -1;
            for (int v = 0; v < NV; v++)
                if (tgt < 0 && m_gate[v] != 0 && m_note[v] == note) tgt = v;
            for (int v = 0; v < NV; v++)
                if (tgt < 0 && m_gate[v] == 0) tgt = v;
            if (tgt < 0) begin
                tgt = 0;
                for (int v = 1; v < NV; v++)
                    if (m_age[v] > m_age[tgt]) tgt = v;
                exp_steal = 1;
            end
            for (int v = 0; v < NV; v++)
                if (v != tgt && m_gate[v] != 0 && m_age[v] < AGE_MAX) m_age[v]++;
            m_gate[tgt] = 1; m_note[tgt] = note; m_freq[tgt] = ref_freq(note);
            m_ctrl[tgt] = wave; m_age[tgt] = 0;
            exp_rst = 1 << tgt;
        end else if (typ == 0) begin
            for (int v = 0; v < NV; v++)
                if (m_gate[v] != 0 && m_note[v] == note) m_gate[v] = 0;
        end else if (typ == 2) begin
            for (int v = 0; v < NV; v++) m_gate[v] = 0;
        end
    endtask

    task automatic check_all(input int exp_rst, input int exp_steal, input int exp_ready);
        for (int v = 0; v < NV; v++) begin
            chk($sformatf("freq[%0d]", v), 32'(voice_freq[20*v +: 20]), m_freq[v]);
            chk($sformatf("ctrl[%0d]", v), 32'(voice_ctrl[2*v +: 2]), m_ctrl[v]);
            chk($sformatf("gate[%0d]", v), 32'(voice_gate[v]), m_gate[v]);
            chk($sformatf("age[%0d]", v), 32'(dut.age_q[v]), m_age[v]);
        end
        chk("voice_rst", 32'(voice_rst), exp_rst);
        chk("steal", 32'(steal), exp_steal);
        chk("ev_ready", 32'(ev_ready), exp_ready);
    endtask

    task automatic send(input int typ, input int note, input int wave);
        int w;
        int exp_rst;
        int exp_steal;
        w = 0;
        while (ev_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(ev_ready), 1);
        ev_type  = 2'(typ);
        ev_note  = 7'(note);
        ev_wave  = 2'(wave);
        ev_valid = 1'b1;
        @(posedge clk);
        #1;
        // Busy-time input garbage must be ignored.
        ev_valid = 1'($urandom_range(0, 1));
        ev_type  = 2'($urandom);
        ev_note  = 7'($urandom);
        ev_wave  = 2'($urandom);
        model_event(typ, note, wave, exp_rst, exp_steal);
        repeat (NV + 1) begin
            @(negedge clk);
            chk("busy_ready", 32'(ev_ready), 0);
            chk("busy_rst", 32'(voice_rst), 0);
        end
        @(negedge clk);
        ev_valid = 1'b0;
        check_all(exp_rst, exp_steal, 1);
        @(negedge clk);
        chk("rst_pulse_end", 32'(voice_rst), 0);
        chk("steal_pulse_end", 32'(steal), 0);
    endtask

    initial begin
        int r;
        int nt;
        reset    = 1'b1;
        ev_valid = 1'b1;
        ev_type  = 2'b01;
        ev_note  = 7'd42;
        ev_wave  = 2'b11;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_all(0, 0, 1);

        // First note lands on voice 0.
        send(1, 69, 1);
        chk("anchor69", 32'(voice_freq[19:0]), 14080);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_all(0, 0, 1);

        send(1, 57, 0);
        chk("anchor57", 32'(voice_freq[19:0]), 7040);
        send(1, 60, 2);
        send(1, 64, 3);
        send(1, 67, 1);
        send(1, 81, 2);
        chk("anchor81", 32'(voice_freq[19:0]), 28160);
        send(1, 64, 0);
        send(0, 64, 0);
        send(0, 100, 0);
        send(3, 57, 1);
        send(2, 0, 0);
        send(1, 0, 1);
        send(1, 127, 2);
        send(1, 127, 3);

        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            nt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : 40 + $urandom_range(0, 7);
            if (r < 5)      send(1, nt, $urandom_range(0, 3));
            else if (r < 8) send(0, nt, $urandom_range(0, 3));
            else if (r < 9) send(2, nt, $urandom_range(0, 3));
            else            send(3, nt, $urandom_range(0, 3));
        end

        // Age saturation: keep retriggering one voice while another ages.
        send(2, 0, 0);
        send(1, 10, 0);
        send(1, 20, 1);
        for (int i = 0; i < 260; i++) send(1, 20, i % 4);

        // Reset two cycles into SCAN abandons the event.
        ev_type  = 2'b01;
        ev_note  = 7'd90;
        ev_wave  = 2'b10;
        ev_valid = 1'b1;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_all(0, 0, 1);
        repeat (NV + 3) begin
            @(negedge clk);
            chk("abandon_gate", 32'(voice_gate), 0);
            chk("abandon_rst", 32'(voice_rst), 0);
        end
        send(1, 72, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
